// File: rtl/mole_scheduler.sv
// -----------------------------------------------------------------------------
// mole_scheduler
//   Spawn sequencer for a multi-hole whack-a-mole game. A shared RNG delay
//   (in ms) paces mole placement. Each placed mole lives LIFE_BASE_MS >> level
//   ms unless hit. Per-cycle hit / miss / whiff counts feed the score datapath.
//
// Ports
//   clk           system clock
//   reset_n       synchronous active-low reset
//   enable        game running; low forces IDLE and clears every mole silently
//   ms_tick       one-cycle pulse per millisecond
//   level         difficulty 0..3 (sampled at placement time)
//   random_value  spawn delay candidate in ms (0 is treated as 1)
//   hole_rand     starting hole for the free-hole scan
//   hit           per-hole button edge pulses
//   mole_on       mole visible per hole (LED drive)
//   spawn_pulse   one cycle, aligned with the new mole appearing
//   full_pulse    one cycle when a placement found no free hole
//   hit_count     valid hits in the previous cycle
//   miss_count    moles that expired unhit in the previous cycle
//   whiff_count   hits on empty holes in the previous cycle
//   busy          sequencer is not idle
// -----------------------------------------------------------------------------
module mole_scheduler #(
    parameter int NUM_HOLES    = 4,
    parameter int MAX_MS       = 2047,
    parameter int LIFE_BASE_MS = 1500
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               enable,
    input  logic                               ms_tick,
    input  logic [1:0]                         level,
    input  logic [$clog2(MAX_MS)-1:0]          random_value,
    input  logic [$clog2(NUM_HOLES)-1:0]       hole_rand,
    input  logic [NUM_HOLES-1:0]               hit,
    output logic [NUM_HOLES-1:0]               mole_on,
    output logic                               spawn_pulse,
    output logic                               full_pulse,
    output logic [$clog2(NUM_HOLES+1)-1:0]     hit_count,
    output logic [$clog2(NUM_HOLES+1)-1:0]     miss_count,
    output logic [$clog2(NUM_HOLES+1)-1:0]     whiff_count,
    output logic                               busy
);

    localparam int TW = $clog2(MAX_MS);
    localparam int HW = $clog2(NUM_HOLES);
    localparam int CW = $clog2(NUM_HOLES + 1);

    localparam logic [TW-1:0] LIFE_BASE = TW'(LIFE_BASE_MS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_PLACE = 2'd3;

    // Population count of a per-hole event vector.
    function automatic logic [CW-1:0] count_ones(input logic [NUM_HOLES-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_HOLES; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    // One-hot select of the first free hole scanning from 'start' with wrap.
    function automatic logic [NUM_HOLES-1:0] pick_hole(input logic [NUM_HOLES-1:0] occ,
                                                       input logic [HW-1:0]        start);
        logic [NUM_HOLES-1:0] sel;
        logic                 found;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_HOLES; k++) begin
            for (int i = 0; i < NUM_HOLES; i++) begin
                if (!found && !occ[i] && (i == ((int'(start) + k) % NUM_HOLES))) begin
                    sel[i] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
        return sel;
    endfunction

    logic [1:0]                  state_q, state_d;
    logic [TW-1:0]               spawn_cnt_q, spawn_cnt_d;
    logic [NUM_HOLES-1:0]        mole_q, mole_d;
    logic [NUM_HOLES-1:0][TW-1:0] life_q, life_d;
    logic                        spawn_q, spawn_d;
    logic                        full_q, full_d;
    logic [CW-1:0]               hit_cnt_q, hit_cnt_d;
    logic [CW-1:0]               miss_cnt_q, miss_cnt_d;
    logic [CW-1:0]               whiff_cnt_q, whiff_cnt_d;
    logic                        busy_q, busy_d;

    logic [NUM_HOLES-1:0]        place_sel_s;
    logic                        place_found_s;
    logic                        do_place_s;
    logic [NUM_HOLES-1:0]        miss_vec_s;
    logic [TW-1:0]               life_load_s;

    // Eligibility uses mole state at the start of the cycle, so a hole
    // freed this cycle by a hit or expiry is never chosen.
    assign place_sel_s   = pick_hole(mole_q, hole_rand);
    assign place_found_s = |place_sel_s;
    assign do_place_s    = (state_q == S_PLACE) && enable;
    assign life_load_s   = LIFE_BASE >> level;

    // Spawn-delay sequencer next state.
    always_comb begin
        state_d     = state_q;
        spawn_cnt_d = spawn_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                spawn_cnt_d = (random_value == '0) ? TW'(1) : random_value;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                if (ms_tick) begin
                    if (spawn_cnt_q <= TW'(1)) begin
                        spawn_cnt_d = '0;
                        state_d     = S_PLACE;
                    end else begin
                        spawn_cnt_d = spawn_cnt_q - TW'(1);
                    end
                end else begin
                    spawn_cnt_d = spawn_cnt_q;
                end
            end
            S_PLACE: begin
                state_d = S_LOAD;
            end
            default: begin
                state_d     = S_IDLE;
                spawn_cnt_d = '0;
            end
        endcase
        if (!enable) begin
            state_d     = S_IDLE;
            spawn_cnt_d = '0;
        end else begin
            state_d = state_d;
        end
    end

    // Per-hole lifetime, hit resolution and placement; hit beats expiry.
    always_comb begin
        mole_d     = mole_q;
        life_d     = life_q;
        miss_vec_s = '0;
        for (int i = 0; i < NUM_HOLES; i++) begin
            if (mole_q[i]) begin
                if (hit[i]) begin
                    mole_d[i] = 1'b0;
                    life_d[i] = '0;
                end else if (ms_tick && (life_q[i] <= TW'(1))) begin
                    mole_d[i]     = 1'b0;
                    life_d[i]     = '0;
                    miss_vec_s[i] = 1'b1;
                end else if (ms_tick) begin
                    life_d[i] = life_q[i] - TW'(1);
                end else begin
                    life_d[i] = life_q[i];
                end
            end else if (do_place_s && place_sel_s[i]) begin
                mole_d[i] = 1'b1;
                life_d[i] = life_load_s;
            end else begin
                mole_d[i] = 1'b0;
            end
        end
        if (!enable) begin
            mole_d     = '0;
            life_d     = '0;
            miss_vec_s = '0;
        end else begin
            mole_d = mole_d;
        end
    end

    // Registered pulses and event counts, all forced quiet while disabled.
    always_comb begin
        spawn_d     = do_place_s && place_found_s;
        full_d      = do_place_s && !place_found_s;
        hit_cnt_d   = count_ones(hit & mole_q);
        whiff_cnt_d = count_ones(hit & ~mole_q);
        miss_cnt_d  = count_ones(miss_vec_s);
        busy_d      = (state_d != S_IDLE);
        if (!enable) begin
            hit_cnt_d   = '0;
            whiff_cnt_d = '0;
            miss_cnt_d  = '0;
        end else begin
            hit_cnt_d = hit_cnt_d;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            spawn_cnt_q <= '0;
            mole_q      <= '0;
            life_q      <= '0;
            spawn_q     <= 1'b0;
            full_q      <= 1'b0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            whiff_cnt_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            spawn_cnt_q <= spawn_cnt_d;
            mole_q      <= mole_d;
            life_q      <= life_d;
            spawn_q     <= spawn_d;
            full_q      <= full_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            whiff_cnt_q <= whiff_cnt_d;
            busy_q      <= busy_d;
        end
    end

    assign mole_on     = mole_q;
    assign spawn_pulse = spawn_q;
    assign full_pulse  = full_q;
    assign hit_count   = hit_cnt_q;
    assign miss_count  = miss_cnt_q;
    assign whiff_count = whiff_cnt_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mole_scheduler
//   Directed bench for mole_scheduler with default parameters (4 holes,
//   11-bit delay, 1500 ms base lifetime). Inputs change 1 ns after the rising
//   edge and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_mole_scheduler;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        ms_tick;
    logic [1:0]  level;
    logic [10:0] random_value;
    logic [1:0]  hole_rand;
    logic [3:0]  hit;
    logic [3:0]  mole_on;
    logic        spawn_pulse;
    logic        full_pulse;
    logic [2:0]  hit_count;
    logic [2:0]  miss_count;
    logic [2:0]  whiff_count;
    logic        busy;

    int n_cmp;
    int n_err;

    mole_scheduler dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .ms_tick      (ms_tick),
        .level        (level),
        .random_value (random_value),
        .hole_rand    (hole_rand),
        .hit          (hit),
        .mole_on      (mole_on),
        .spawn_pulse  (spawn_pulse),
        .full_pulse   (full_pulse),
        .hit_count    (hit_count),
        .miss_count   (miss_count),
        .whiff_count  (whiff_count),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        ms_tick = 1'b1;
        @(posedge clk);
        #1;
        ms_tick = 1'b0;
    endtask

    // Reset, then enable; returns with the sequencer in WAIT holding rv.
    task automatic start(input logic [10:0] rv);
        enable  = 1'b0;
        ms_tick = 1'b0;
        hit     = 4'b0000;
        reset_n = 1'b0;
        step();
        step();
        reset_n      = 1'b1;
        enable       = 1'b1;
        random_value = rv;
        step();
        step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        enable  = 1'b1;
        hit     = 4'b1111;
        ms_tick = 1'b1;
        step();
        step();
        n_cmp++;
        if ({mole_on, spawn_pulse, full_pulse, busy} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got mole=%b sp=%b fp=%b busy=%b want 0", mole_on, spawn_pulse, full_pulse, busy);
        end
        n_cmp++;
        if ({hit_count, miss_count, whiff_count} !== 9'b0) begin
            n_err++;
            $display("FAIL reset_counts: got h=%0d m=%0d w=%0d want 0", hit_count, miss_count, whiff_count);
        end
        hit     = 4'b0000;
        ms_tick = 1'b0;
    endtask

    // Spawn after 3 ticks, 1500 ms lifetime, then a 2047-tick spawn delay.
    task automatic test_spawn_expire();
        level     = 2'd0;
        hole_rand = 2'd2;
        start(11'd3);
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL busy_wait: got %b want 1", busy); end
        tick();
        tick();
        tick();
        n_cmp++;
        if (mole_on !== 4'b0000) begin n_err++; $display("FAIL early_spawn: got %b want 0000", mole_on); end
        random_value = 11'd2047;
        step();
        n_cmp++;
        if ({mole_on, spawn_pulse} !== 5'b0100_1) begin
            n_err++;
            $display("FAIL first_spawn: got mole=%b sp=%b want 0100/1", mole_on, spawn_pulse);
        end
        step();
        n_cmp++;
        if (spawn_pulse !== 1'b0) begin n_err++; $display("FAIL spawn_one_cycle: got %b want 0", spawn_pulse); end
        repeat (1499) tick();
        n_cmp++;
        if ({mole_on, miss_count} !== 7'b0100_000) begin
            n_err++;
            $display("FAIL life_1499: got mole=%b miss=%0d want 0100/0", mole_on, miss_count);
        end
        tick();
        n_cmp++;
        if ({mole_on, miss_count} !== 7'b0000_001) begin
            n_err++;
            $display("FAIL expire_1500: got mole=%b miss=%0d want 0000/1", mole_on, miss_count);
        end
        step();
        n_cmp++;
        if (miss_count !== 3'd0) begin n_err++; $display("FAIL miss_one_cycle: got %0d want 0", miss_count); end
        // 1500 of the 2047 delay ticks have elapsed.
        repeat (546) tick();
        step();
        n_cmp++;
        if ({mole_on, spawn_pulse} !== 5'b0) begin
            n_err++;
            $display("FAIL spawn_2046: got mole=%b sp=%b want 0000/0", mole_on, spawn_pulse);
        end
        tick();
        step();
        n_cmp++;
        if ({mole_on, spawn_pulse} !== 5'b0100_1) begin
            n_err++;
            $display("FAIL spawn_2047: got mole=%b sp=%b want 0100/1", mole_on, spawn_pulse);
        end
    endtask

    task automatic test_zero_delay();
        hole_rand = 2'd1;
        level     = 2'd0;
        start(11'd0);
        tick();
        random_value = 11'd2047;
        step();
        n_cmp++;
        if ({mole_on, spawn_pulse} !== 5'b0010_1) begin
            n_err++;
            $display("FAIL zero_delay: got mole=%b sp=%b want 0010/1", mole_on, spawn_pulse);
        end
    endtask

    task automatic test_hit_level();
        logic miss_seen;
        level     = 2'd2;
        hole_rand = 2'd3;
        start(11'd1);
        tick();
        random_value = 11'd2047;
        step();
        n_cmp++;
        if (mole_on !== 4'b1000) begin n_err++; $display("FAIL lvl2_place: got %b want 1000", mole_on); end
        repeat (100) tick();
        hit = 4'b1000;
        step();
        hit = 4'b0000;
        n_cmp++;
        if ({mole_on, hit_count, miss_count} !== 10'b0000_001_000) begin
            n_err++;
            $display("FAIL lvl2_hit: got mole=%b h=%0d m=%0d want 0000/1/0", mole_on, hit_count, miss_count);
        end
        step();
        n_cmp++;
        if (hit_count !== 3'd0) begin n_err++; $display("FAIL hit_one_cycle: got %0d want 0", hit_count); end
        miss_seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (miss_count !== 3'd0) miss_seen = 1'b1;
        end
        n_cmp++;
        if (miss_seen !== 1'b0) begin n_err++; $display("FAIL miss_after_hit: got %b want 0", miss_seen); end
        // Unhit lifetime at level 2 is 375; a later level change must not matter.
        level     = 2'd2;
        hole_rand = 2'd0;
        start(11'd1);
        tick();
        random_value = 11'd2047;
        step();
        level = 2'd0;
        repeat (374) tick();
        n_cmp++;
        if (mole_on !== 4'b0001) begin n_err++; $display("FAIL lvl2_life_374: got %b want 0001", mole_on); end
        tick();
        n_cmp++;
        if ({mole_on, miss_count} !== 7'b0000_001) begin
            n_err++;
            $display("FAIL lvl2_expire_375: got mole=%b miss=%0d want 0000/1", mole_on, miss_count);
        end
    endtask

    task automatic test_wrap_full();
        level     = 2'd0;
        hole_rand = 2'd2;
        start(11'd1);
        tick();
        step();
        step();
        hole_rand = 2'd3;
        tick();
        step();
        n_cmp++;
        if (mole_on !== 4'b1100) begin n_err++; $display("FAIL fill_2_3: got %b want 1100", mole_on); end
        step();
        hole_rand = 2'd2;
        tick();
        step();
        n_cmp++;
        if ({mole_on, spawn_pulse} !== 5'b1101_1) begin
            n_err++;
            $display("FAIL wrap_to_0: got mole=%b sp=%b want 1101/1", mole_on, spawn_pulse);
        end
        step();
        hole_rand = 2'd0;
        tick();
        step();
        n_cmp++;
        if (mole_on !== 4'b1111) begin n_err++; $display("FAIL fill_1: got %b want 1111", mole_on); end
        step();
        tick();
        step();
        n_cmp++;
        if ({mole_on, spawn_pulse, full_pulse} !== 6'b1111_0_1) begin
            n_err++;
            $display("FAIL full: got mole=%b sp=%b fp=%b want 1111/0/1", mole_on, spawn_pulse, full_pulse);
        end
        step();
        n_cmp++;
        if (full_pulse !== 1'b0) begin n_err++; $display("FAIL full_one_cycle: got %b want 0", full_pulse); end
    endtask

    task automatic test_hit_vs_expire_whiff();
        level     = 2'd3;
        hole_rand = 2'd1;
        start(11'd1);
        tick();
        random_value = 11'd2047;
        step();
        repeat (186) tick();
        n_cmp++;
        if (mole_on !== 4'b0010) begin n_err++; $display("FAIL lvl3_life_186: got %b want 0010", mole_on); end
        hit     = 4'b0010;
        ms_tick = 1'b1;
        step();
        hit     = 4'b0000;
        ms_tick = 1'b0;
        n_cmp++;
        if ({mole_on, hit_count, miss_count} !== 10'b0000_001_000) begin
            n_err++;
            $display("FAIL hit_beats_expire: got mole=%b h=%0d m=%0d want 0000/1/0", mole_on, hit_count, miss_count);
        end
        hit = 4'b0001;
        step();
        hit = 4'b0000;
        n_cmp++;
        if ({hit_count, whiff_count} !== 6'b000_001) begin
            n_err++;
            $display("FAIL whiff_one: got h=%0d w=%0d want 0/1", hit_count, whiff_count);
        end
        hit = 4'b1111;
        step();
        hit = 4'b0000;
        n_cmp++;
        if (whiff_count !== 3'd4) begin n_err++; $display("FAIL whiff_all: got %0d want 4", whiff_count); end
        // Hit landing on the placement cycle is a whiff; the mole still spawns.
        hole_rand = 2'd2;
        start(11'd1);
        tick();
        hit          = 4'b0100;
        random_value = 11'd2047;
        step();
        hit = 4'b0000;
        n_cmp++;
        if ({mole_on, spawn_pulse, hit_count, whiff_count} !== 11'b0100_1_000_001) begin
            n_err++;
            $display("FAIL hit_on_place: got mole=%b sp=%b h=%0d w=%0d want 0100/1/0/1",
                     mole_on, spawn_pulse, hit_count, whiff_count);
        end
    endtask

    task automatic test_disable_reset();
        for (int pass = 0; pass < 2; pass++) begin
            level     = 2'd0;
            hole_rand = 2'd0;
            start(11'd1);
            tick();
            random_value = 11'd1;
            step();
            step();
            hole_rand = 2'd1;
            tick();
            random_value = 11'd2047;
            step();
            step();
            repeat (5) tick();
            n_cmp++;
            if ({mole_on, busy} !== 5'b0011_1) begin
                n_err++;
                $display("FAIL two_moles_p%0d: got mole=%b busy=%b want 0011/1", pass, mole_on, busy);
            end
            hit     = 4'b0101;
            ms_tick = 1'b1;
            if (pass == 0) enable = 1'b0;
            else reset_n = 1'b0;
            step();
            hit     = 4'b0000;
            ms_tick = 1'b0;
            n_cmp++;
            if ({mole_on, busy, spawn_pulse, full_pulse} !== 7'b0) begin
                n_err++;
                $display("FAIL stop_outputs_p%0d: got mole=%b busy=%b sp=%b fp=%b want 0",
                         pass, mole_on, busy, spawn_pulse, full_pulse);
            end
            n_cmp++;
            if ({hit_count, miss_count, whiff_count} !== 9'b0) begin
                n_err++;
                $display("FAIL stop_counts_p%0d: got h=%0d m=%0d w=%0d want 0",
                         pass, hit_count, miss_count, whiff_count);
            end
        end
        reset_n = 1'b1;
        enable  = 1'b0;
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        reset_n      = 1'b0;
        enable       = 1'b0;
        ms_tick      = 1'b0;
        level        = 2'd0;
        random_value = 11'd0;
        hole_rand    = 2'd0;
        hit          = 4'b0000;
        test_reset();
        test_spawn_expire();
        test_zero_delay();
        test_hit_level();
        test_wrap_full();
        test_hit_vs_expire_whiff();
        test_disable_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
